panic_credit_scheduler: RTL and testbench
=========================================

# panic_credit_scheduler

Credit-based dispatcher placed between the PANIC packet-descriptor path and the offload engine crossbar ports. It accepts one descriptor per cycle, each carrying an eligible-engine mask. It grants the descriptor to one eligible engine that holds credit, using round-robin order. It tracks per-engine credits, which engines return as they free buffer slots. Engine chains such as A(A1, A2, A3) share load without overrunning any engine.

## Interface
- ENGINE_NUM, 4, number of engines/credit pools (2..8)
- INIT_CREDIT_NUM, 4, credits per engine after reset; also the saturation ceiling
- CREDIT_WIDTH, 4, counter width; must hold INIT_CREDIT_NUM
- DESC_WIDTH, 64, opaque descriptor payload width
- clk  in  1  clock
- rst  in  1  reset
- s_desc_valid  in  1  descriptor offered
- s_desc_ready  out  1  descriptor accepted this cycle when valid & ready
- s_desc_data  in  DESC_WIDTH  payload
- s_desc_mask  in  ENGINE_NUM  bit k=1: engine k may serve this descriptor
- m_desc_valid  out  1  granted descriptor available
- m_desc_ready  in  1  downstream (crossbar) accepts
- m_desc_data  out  DESC_WIDTH  registered payload
- m_desc_engine  out  IDX_W  granted engine index; IDX_W = max(1, $clog2(ENGINE_NUM))
- credit_return  in  ENGINE_NUM  one-cycle pulse per returned credit, per engine
- credit_avail  out  ENGINE_NUM*CREDIT_WIDTH  current counters, engine k at [k*CREDIT_WIDTH +: CREDIT_WIDTH]
- err_overflow  out  1  sticky: return received at ceiling
- err_bad_mask  out  1  sticky: descriptor with zero mask seen
- stat_dispatch  out  32  descriptors granted (SCHED_STATS_EN)
- stat_stall  out  32  stall cycles (SCHED_STATS_EN)
- Reset is rst: synchronous, active-high. Clock is clk.

## Operation
- Output stage FSM has two states. EMPTY means m_desc_valid=0. FULL means m_desc_valid=1.
  - EMPTY→FULL on an accept with mask≠0.
  - FULL→EMPTY on m_desc_ready when there is no new accept.
  - FULL stays FULL when m_desc_ready and an accept occur in the same cycle (back-to-back).
- eligible = s_desc_mask & {credit_k != 0}. This is computed combinationally from the registered counters.
- s_desc_ready = (EMPTY or m_desc_ready) and (eligible≠0 or s_desc_mask==0).
- Grant selects the first set bit of eligible, searching upward from rr_ptr with wrap modulo ENGINE_NUM.
  - After a grant to engine k, rr_ptr = (k+1) mod ENGINE_NUM.
  - rr_ptr resets to 0.
- On accept, the payload and grant index are loaded into the output registers, and credit_k of the granted engine is decremented.
- On credit_return[k], credit_k increments.
  - If a grant to k and a return to k occur in the same cycle, credit_k is unchanged.
  - A return when credit_k == INIT_CREDIT_NUM and there is no same-cycle grant holds the counter at INIT_CREDIT_NUM and sets err_overflow.
- Zero-mask descriptor: it is accepted whenever the output stage can take data. It is dropped (no output, no credit change, rr_ptr unchanged), and err_bad_mask is set.
- Sticky error flags clear only on rst.
- Reset values:
  - credits = INIT_CREDIT_NUM for every engine
  - m_desc_valid = 0
  - m_desc_data = 0, m_desc_engine = 0
  - err flags = 0, stat counters = 0
- Reset mid-operation discards any held output descriptor. Credits outstanding at engines are forgotten. Engines must be reset together with this block.

## Timing
- Latency: accept in cycle N → m_desc_valid in cycle N+1.
- Sustained throughput is 1 descriptor/cycle while m_desc_ready=1 and credit is available.
- m_desc_data and m_desc_engine remain stable while m_desc_valid=1 and m_desc_ready=0.
- A returned credit is visible in credit_avail, and usable for a grant, in the cycle after the pulse.
- A decrement is visible in the cycle after the accept.
- s_desc_ready depends combinationally on s_desc_mask and m_desc_ready. There is no dependency on s_desc_valid.

## Configuration
- SCHED_STATS_EN defined:
  - stat_dispatch increments on each grant.
  - stat_stall increments each cycle where s_desc_valid=1 and s_desc_ready=0.
  - Both counters wrap at 2^32.
- SCHED_STATS_EN undefined: stat_dispatch and stat_stall are tied to 0 and no counter logic is built.

## Test plan
- Reset, mask=4'b1111, 16 back-to-back descriptors with m_desc_ready=1, no returns → engines granted 0,1,2,3 repeating ×4. s_desc_ready drops on the 17th offer. All credits read 0.
- Masks all 4'b0100, INIT_CREDIT_NUM=4 → 4 grants to engine 2, then stall. A credit_return[2] pulse in cycle T → next grant accepted in T+1, output valid T+2.
- Grant to engine 1 coinciding with credit_return[1] → credit_1 unchanged. Pulse credit_return[0] at full credit → counter stays 4 and err_overflow=1 until rst.
- m_desc_ready held low for 5 cycles with a descriptor pending → m_desc_data and m_desc_engine stable, s_desc_ready=0, stat_stall +5 (SCHED_STATS_EN).
- Zero-mask descriptor between two mask=4'b0011 descriptors → only 2 outputs (engines 0 then 1), err_bad_mask=1, credits 3/3/4/4.
- Assert rst while FULL with credits partly consumed → next cycle m_desc_valid=0, all credits=4, rr_ptr=0, stats=0.

Source files
------------

// File: rtl/panic_credit_scheduler.sv
// panic_credit_scheduler: credit-based round-robin dispatcher between the
// PANIC descriptor path and the offload engine crossbar ports.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_desc_*            descriptor input (valid/ready, data, eligible mask)
//   m_desc_*            registered granted descriptor (valid/ready, data,
//                       engine index)
//   credit_return       per-engine one-cycle credit return pulses
//   credit_avail        packed per-engine credit counters
//   err_overflow        sticky: credit returned while at the ceiling
//   err_bad_mask        sticky: zero-mask descriptor seen
//   stat_dispatch       grant counter (SCHED_STATS_EN), else 0
//   stat_stall          valid-but-not-ready cycles (SCHED_STATS_EN), else 0
//
// Optional build macro: SCHED_STATS_EN enables the two statistics counters.

module panic_credit_scheduler #(
   parameter int ENGINE_NUM      = 4,
   parameter int INIT_CREDIT_NUM = 4,
   parameter int CREDIT_WIDTH    = 4,
   parameter int DESC_WIDTH      = 64,
   localparam int IDX_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_desc_valid,
   output logic                             s_desc_ready,
   input  logic [DESC_WIDTH-1:0]            s_desc_data,
   input  logic [ENGINE_NUM-1:0]            s_desc_mask,
   output logic                             m_desc_valid,
   input  logic                             m_desc_ready,
   output logic [DESC_WIDTH-1:0]            m_desc_data,
   output logic [IDX_W-1:0]                 m_desc_engine,
   input  logic [ENGINE_NUM-1:0]            credit_return,
   output logic [ENGINE_NUM*CREDIT_WIDTH-1:0] credit_avail,
   output logic                             err_overflow,
   output logic                             err_bad_mask,
   output logic [31:0]                      stat_dispatch,
   output logic [31:0]                      stat_stall
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CREDIT_WIDTH-1:0] CRED_MAX =
      CREDIT_WIDTH'(INIT_CREDIT_NUM);

   state_t                  state_q;
   state_t                  state_d;
   logic [CREDIT_WIDTH-1:0] credit_q [ENGINE_NUM];
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        gnt_idx;
   logic [IDX_W-1:0]        rr_next;
   logic [ENGINE_NUM-1:0]   eligible;
   logic [ENGINE_NUM-1:0]   gnt_onehot;
   logic [ENGINE_NUM-1:0]   ovf_hit;
   logic                    take_ok;
   logic                    mask_zero;
   logic                    accept;
   logic                    grant;
   logic                    drop;

   // Eligibility comes from registered counters only, so a returned credit
   // becomes usable one cycle after its pulse.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < ENGINE_NUM; k++) begin
         eligible[k] = s_desc_mask[k] && (credit_q[k] != '0);
      end
   end

   assign take_ok      = (state_q == EMPTY) || m_desc_ready;
   assign mask_zero    = (s_desc_mask == '0);
   assign s_desc_ready = take_ok && ((|eligible) || mask_zero);
   assign accept       = s_desc_valid && s_desc_ready;
   assign grant        = accept && !mask_zero;
   assign drop         = accept && mask_zero;

   // Round-robin search: first eligible engine at or after rr_ptr.
   always_comb begin
      int  j;
      logic found;
      j       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < ENGINE_NUM; i++) begin
         j = (int'(rr_ptr) + i) % ENGINE_NUM;
         if (!found && eligible[j]) begin
            found   = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

   assign rr_next = (gnt_idx == IDX_W'(ENGINE_NUM - 1)) ?
                    '0 : gnt_idx + 1'b1;

   always_comb begin
      gnt_onehot = '0;
      ovf_hit    = '0;
      for (int k = 0; k < ENGINE_NUM; k++) begin
         gnt_onehot[k] = grant && (gnt_idx == IDX_W'(k));
         ovf_hit[k]    = credit_return[k] && !gnt_onehot[k] &&
                         (credit_q[k] == CRED_MAX);
      end
   end

   // A grant and a return to the same engine cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ENGINE_NUM; k++) begin
            credit_q[k] <= CRED_MAX;
         end
      end else begin
         for (int k = 0; k < ENGINE_NUM; k++) begin
            if (credit_return[k] && !gnt_onehot[k]) begin
               if (credit_q[k] != CRED_MAX) begin
                  credit_q[k] <= credit_q[k] + 1'b1;
               end
            end else if (gnt_onehot[k] && !credit_return[k]) begin
               credit_q[k] <= credit_q[k] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      credit_avail = '0;
      for (int k = 0; k < ENGINE_NUM; k++) begin
         credit_avail[k*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr        <= '0;
         m_desc_data   <= '0;
         m_desc_engine <= '0;
         err_overflow  <= 1'b0;
         err_bad_mask  <= 1'b0;
      end else begin
         if (grant) begin
            rr_ptr        <= rr_next;
            m_desc_data   <= s_desc_data;
            m_desc_engine <= gnt_idx;
         end
         if (|ovf_hit) begin
            err_overflow <= 1'b1;
         end
         if (drop) begin
            err_bad_mask <= 1'b1;
         end
      end
   end

   // Output stage FSM: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Output stage FSM: next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (grant) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (m_desc_ready && !grant) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output stage FSM: outputs.
   always_comb begin
      m_desc_valid = (state_q == FULL);
   end

`ifdef SCHED_STATS_EN
   logic [31:0] dispatch_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dispatch_q <= '0;
         stall_q    <= '0;
      end else begin
         if (grant) begin
            dispatch_q <= dispatch_q + 32'd1;
         end
         if (s_desc_valid && !s_desc_ready) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign stat_dispatch = dispatch_q;
   assign stat_stall    = stall_q;
`else
   assign stat_dispatch = 32'd0;
   assign stat_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_panic_credit_scheduler.sv
// tb_panic_credit_scheduler: scoreboard bench for panic_credit_scheduler.
// Directed scenarios followed by randomized traffic against a queue model.

module tb_panic_credit_scheduler;

   localparam int N    = 4;
   localparam int INIT = 4;
   localparam int CW   = 4;
   localparam int DW   = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_desc_valid = 1'b0;
   logic          s_desc_ready;
   logic [DW-1:0] s_desc_data = '0;
   logic [N-1:0]  s_desc_mask = '0;
   logic          m_desc_valid;
   logic          m_desc_ready = 1'b0;
   logic [DW-1:0] m_desc_data;
   logic [1:0]    m_desc_engine;
   logic [N-1:0]  credit_return = '0;
   logic [N*CW-1:0] credit_avail;
   logic          err_overflow;
   logic          err_bad_mask;
   logic [31:0]   stat_dispatch;
   logic [31:0]   stat_stall;

   panic_credit_scheduler #(
      .ENGINE_NUM(N), .INIT_CREDIT_NUM(INIT),
      .CREDIT_WIDTH(CW), .DESC_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
      .s_desc_data(s_desc_data), .s_desc_mask(s_desc_mask),
      .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
      .m_desc_data(m_desc_data), .m_desc_engine(m_desc_engine),
      .credit_return(credit_return), .credit_avail(credit_avail),
      .err_overflow(err_overflow), .err_bad_mask(err_bad_mask),
      .stat_dispatch(stat_dispatch), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            e;
   } exp_t;

   exp_t        q[$];
   int          cred[N];
   int          rr;
   bit          m_ovf;
   bit          m_bad;
   int unsigned m_disp;
   int unsigned m_stall;
   int          compared = 0;
   int          mismatched = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < N; k++) cred[k] = INIT;
      rr      = 0;
      m_ovf   = 0;
      m_bad   = 0;
      m_disp  = 0;
      m_stall = 0;
      q.delete();
   endfunction

   // Output monitor: the held descriptor must match the queue head every
   // cycle it is presented; it leaves the queue when the crossbar takes it.
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_valid", m_desc_valid, q.size() != 0);
         if (m_desc_valid && q.size() != 0) begin
            chk("m_data", m_desc_data, q[0].d);
            chk("m_engine", m_desc_engine, q[0].e);
            if (m_desc_ready) void'(q.pop_front());
         end
      end
   end

   // One cycle: drive, predict, check registered state, then advance model.
   task automatic step(input bit v, input logic [N-1:0] m,
                       input logic [DW-1:0] d, input bit r,
                       input logic [N-1:0] cr);
      bit           can;
      bit           sr;
      bit           acc;
      int           g;
      logic [N-1:0] elig;
      s_desc_valid  = v;
      s_desc_mask   = m;
      s_desc_data   = d;
      m_desc_ready  = r;
      credit_return = cr;
      elig = '0;
      for (int k = 0; k < N; k++) elig[k] = m[k] && (cred[k] > 0);
      can = (q.size() == 0) || r;
      sr  = can && (elig != 0 || m == 0);
      @(negedge clk);
      chk("s_ready", s_desc_ready, sr);
      for (int k = 0; k < N; k++)
         chk($sformatf("credit%0d", k), credit_avail[k*CW +: CW], cred[k]);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_bad_mask", err_bad_mask, m_bad);
`ifdef SCHED_STATS_EN
      chk("stat_dispatch", stat_dispatch, m_disp);
      chk("stat_stall", stat_stall, m_stall);
`else
      chk("stat_dispatch", stat_dispatch, 0);
      chk("stat_stall", stat_stall, 0);
`endif
      @(posedge clk);
      acc = v && sr;
      g   = -1;
      if (acc && m != 0) begin
         for (int i = 0; i < N; i++) begin
            if (g < 0 && elig[(rr + i) % N]) g = (rr + i) % N;
         end
         q.push_back('{d: d, e: g});
         rr = (g + 1) % N;
         m_disp++;
      end
      if (acc && m == 0) m_bad = 1;
      if (v && !sr) m_stall++;
      for (int k = 0; k < N; k++) begin
         if (cr[k] && g != k) begin
            if (cred[k] == INIT) m_ovf = 1;
            else cred[k]++;
         end else if (!cr[k] && g == k) begin
            cred[k]--;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      s_desc_valid  = 1'b0;
      m_desc_ready  = 1'b0;
      credit_return = '0;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Full mask, back-to-back: 0,1,2,3 x4 then stall on the 17th offer.
      for (int i = 0; i < 17; i++) step(1, 4'b1111, rnd64(), 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);
      do_reset();

      // Single engine: four grants, stall, then a return reopens it.
      for (int i = 0; i < 5; i++) step(1, 4'b0100, rnd64(), 1, 4'b0);
      step(1, 4'b0100, rnd64(), 1, 4'b0100);
      step(1, 4'b0100, rnd64(), 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);
      do_reset();

      // Grant and return on engine 1 together; return at ceiling on 0.
      step(1, 4'b0010, rnd64(), 1, 4'b0010);
      step(0, 4'b0, '0, 1, 4'b0001);
      step(0, 4'b0, '0, 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);

      // Backpressure for five cycles with a descriptor held.
      step(1, 4'b1111, rnd64(), 1, 4'b0);
      for (int i = 0; i < 5; i++) step(1, 4'b1111, rnd64(), 0, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);
      do_reset();

      // Zero-mask descriptor dropped between two valid ones.
      step(1, 4'b0011, rnd64(), 1, 4'b0);
      step(1, 4'b0000, rnd64(), 1, 4'b0);
      step(1, 4'b0011, rnd64(), 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);

      // Reset while full with credits partly consumed.
      step(1, 4'b1111, rnd64(), 1, 4'b0);
      step(1, 4'b1111, rnd64(), 0, 4'b0);
      do_reset();
      step(1, 4'b1111, rnd64(), 1, 4'b0);
      step(0, 4'b0, '0, 1, 4'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 600) == 0) do_reset();
         step(($urandom % 4) != 0, N'($urandom),
              rnd64(), ($urandom % 4) != 0,
              N'($urandom & $urandom & $urandom));
      end
      step(0, 4'b0, '0, 1, 4'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
